// File: rtl/array_reduce_seq.sv
// Streaming frame reducer: folds N accepted W-bit words into one result
// using a per-frame mode (saturating sum, max, min, xor), valid/ready on both sides.
module array_reduce_seq #(
  parameter int W      = 8,
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_mode;
  logic            r_ovf;
  logic            r_out_valid;
  logic            r_in_ready;
  logic            r_busy;
  logic            w_accept;
  logic            w_xfer;
  logic            w_last;
  logic [W:0]      w_step;

  // One reduction step; returns {overflow, result}. Ties in max/min keep acc.
  function automatic logic [W:0] reduce_step(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [1:0]   m);
    logic [W:0]   wide;
    logic [W-1:0] res;
    logic         ov;
    logic         b_gt_a;
    logic         b_lt_a;
    wide   = {1'b0, a} + {1'b0, b};
    res    = a;
    ov     = 1'b0;
    b_gt_a = SIGNED ? ($signed(b) > $signed(a)) : (b > a);
    b_lt_a = SIGNED ? ($signed(b) < $signed(a)) : (b < a);
    case (m)
      2'd0: begin
        if (SIGNED) begin
          res = wide[W-1:0];
          if ((a[W-1] == b[W-1]) && (res[W-1] != a[W-1])) begin
            ov  = 1'b1;
            res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end else begin
            ov  = 1'b0;
          end
        end else begin
          if (wide[W]) begin
            ov  = 1'b1;
            res = {W{1'b1}};
          end else begin
            ov  = 1'b0;
            res = wide[W-1:0];
          end
        end
      end
      2'd1:    res = b_gt_a ? b : a;
      2'd2:    res = b_lt_a ? b : a;
      2'd3:    res = a ^ b;
      default: res = a;
    endcase
    return {ov, res};
  endfunction

  assign w_accept = in_valid && r_in_ready;
  assign w_xfer   = r_out_valid && out_ready;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_step   = reduce_step(r_acc, in_data, r_mode);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (N == 32'sd1) ? S_HOLD : S_ACCUM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_accept && w_last) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_HOLD: begin
        if (w_xfer) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, beat counter, frame mode and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= {W{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_mode <= 2'd0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc  <= in_data;
        r_mode <= mode;
        r_ovf  <= 1'b0;
        r_cnt  <= CW'(1);
      end else begin
        r_acc  <= w_step[W-1:0];
        r_ovf  <= r_ovf | w_step[W];
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  // Handshake/status outputs registered from the next state so they track r_state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == S_HOLD);
      r_in_ready  <= (w_state_nxt != S_HOLD);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_array_reduce_seq.sv
// Bench for array_reduce_seq: unsigned and signed instances share stimulus;
// expected results come from a vector table and are checked through a scoreboard.
module tb_array_reduce_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       u_in_ready, u_out_valid, u_out_ovf, u_busy;
  logic [7:0] u_out_data;
  logic       s_in_ready, s_out_valid, s_out_ovf, s_busy;
  logic [7:0] s_out_data;

  always #5 clk = ~clk;

  array_reduce_seq #(.W(8), .N(8), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(in_data), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .out_ovf(u_out_ovf), .busy(u_busy)
  );

  array_reduce_seq #(.W(8), .N(8), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  typedef struct {
    logic [7:0] du;
    logic       ou;
    logic [7:0] ds;
    logic       os;
  } exp_t;

  typedef struct {
    logic [1:0]       mode;
    logic [0:7][7:0]  data;
    exp_t             exp;
  } vec_t;

  localparam logic [0:7][7:0] D_SEQ = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  localparam logic [0:7][7:0] D_FF  = {8{8'hFF}};
  localparam logic [0:7][7:0] D_MIX = {8'h80, 8'hFF, 8'h05, 8'h7F, 8'h00, 8'h90, 8'h01, 8'hC0};
  localparam logic [0:7][7:0] D_BND = {8'h70, 8'h10, {6{8'h00}}};
  localparam logic [0:7][7:0] D_CMP = {8'h7F, 8'h80, {6{8'h00}}};

  exp_t sb[$];
  vec_t vecs[12];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: result is popped and compared in the cycle it is transferred
  always @(negedge clk) begin
    if (rst === 1'b0 && u_out_valid === 1'b1) begin
      chk("spurious_valid", (sb.size() != 0), 1);
      if (out_ready === 1'b1 && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("u_data", u_out_data, e.du);
        chk("u_ovf", u_out_ovf, e.ou);
        chk("s_valid", s_out_valid, 1);
        chk("s_data", s_out_data, e.ds);
        chk("s_ovf", s_out_ovf, e.os);
      end
    end
  end

  task automatic send_frame(input logic [1:0] m, input logic [0:7][7:0] d, input bit bubbles,
                            input int chg_beat, input logic [1:0] m_alt, input exp_t e);
    for (int i = 0; i < 8; i++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        in_data  = 8'hAA;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d[i];
      mode     = (chg_beat >= 0 && i >= chg_beat) ? m_alt : m;
      begin
        int t;
        t = 0;
        while (!u_in_ready && t < 50) begin
          @(posedge clk); #1;
          t++;
        end
        if (t >= 50) chk("in_ready_timeout", u_in_ready, 1);
      end
      if (i == 7) begin
        sb.push_back(e);
        chk("valid_before_last", u_out_valid, 0);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("latency_valid", u_out_valid, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (u_out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_idle", u_out_valid, 0);
  endtask

  initial begin
    vecs[0]  = '{mode: 2'd0, data: D_SEQ, exp: '{du: 8'd36,  ou: 1'b0, ds: 8'd36,  os: 1'b0}};
    vecs[1]  = '{mode: 2'd1, data: D_SEQ, exp: '{du: 8'd8,   ou: 1'b0, ds: 8'd8,   os: 1'b0}};
    vecs[2]  = '{mode: 2'd2, data: D_SEQ, exp: '{du: 8'd1,   ou: 1'b0, ds: 8'd1,   os: 1'b0}};
    vecs[3]  = '{mode: 2'd3, data: D_SEQ, exp: '{du: 8'd8,   ou: 1'b0, ds: 8'd8,   os: 1'b0}};
    vecs[4]  = '{mode: 2'd0, data: D_FF,  exp: '{du: 8'hFF,  ou: 1'b1, ds: 8'hF8,  os: 1'b0}};
    vecs[5]  = '{mode: 2'd0, data: D_SEQ, exp: '{du: 8'd36,  ou: 1'b0, ds: 8'd36,  os: 1'b0}};
    vecs[6]  = '{mode: 2'd1, data: D_MIX, exp: '{du: 8'hFF,  ou: 1'b0, ds: 8'h7F,  os: 1'b0}};
    vecs[7]  = '{mode: 2'd2, data: D_MIX, exp: '{du: 8'h00,  ou: 1'b0, ds: 8'h80,  os: 1'b0}};
    vecs[8]  = '{mode: 2'd0, data: D_MIX, exp: '{du: 8'hFF,  ou: 1'b1, ds: 8'h80,  os: 1'b1}};
    vecs[9]  = '{mode: 2'd3, data: D_MIX, exp: '{du: 8'h54,  ou: 1'b0, ds: 8'h54,  os: 1'b0}};
    vecs[10] = '{mode: 2'd0, data: D_BND, exp: '{du: 8'h80,  ou: 1'b0, ds: 8'h7F,  os: 1'b1}};
    vecs[11] = '{mode: 2'd1, data: D_CMP, exp: '{du: 8'h80,  ou: 1'b0, ds: 8'h7F,  os: 1'b0}};

    rst       = 1'b1;
    mode      = 2'd0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", u_out_valid, 0);
    chk("rst_busy", u_busy, 0);
    chk("rst_in_ready", u_in_ready, 1);
    chk("rst_out_data", u_out_data, 0);
    chk("rst_out_ovf", u_out_ovf, 0);

    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i].mode, vecs[i].data, 1'b0, -1, 2'd0, vecs[i].exp);
      wait_idle();
    end

    // Bubbles on the input, then five cycles of output backpressure
    out_ready = 1'b0;
    send_frame(2'd0, D_SEQ, 1'b1, -1, 2'd0, '{du: 8'd36, ou: 1'b0, ds: 8'd36, os: 1'b0});
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", u_out_valid, 1);
      chk("hold_data", u_out_data, 36);
      chk("hold_in_ready", u_in_ready, 0);
      chk("hold_busy", u_busy, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", u_out_valid, 0);
    chk("release_busy", u_busy, 0);
    chk("release_in_ready", u_in_ready, 1);

    // Partial frame aborted by reset, then a frame with a mid-frame mode change
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      mode     = 2'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("partial_busy", u_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", u_busy, 0);
    chk("midrst_in_ready", u_in_ready, 1);
    chk("midrst_out_valid", u_out_valid, 0);
    chk("midrst_out_data", u_out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(2'd1, D_SEQ, 1'b0, 3, 2'd3, '{du: 8'd8, ou: 1'b0, ds: 8'd8, os: 1'b0});
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/array_reduce_seq.md
Name: array_reduce_seq

Overview:
- Streaming successor to the combinational array reducer.
- Accepts an N-element frame of W-bit words, one word per accepted beat, and reduces it to a single W-bit result.
- Reduction modes are selectable per frame: saturating sum, max, min, XOR.
- Sits between an upstream sample stream and any consumer needing one scalar per frame; valid/ready on both sides.

Parameters:
- W, 8, data width in bits.
- N, 8, elements per frame; must be ≥ 1.
- SIGNED, 0, when 1, max/min compare two's-complement and sum saturates signed; when 0, all unsigned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  0=sum, 1=max, 2=min, 3=xor; sampled only on a frame's first accepted beat.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  W  frame element.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  W  reduction result.
- out_ovf  output  1  sum mode only: saturation occurred at any point in this frame; 0 in other modes.
- busy  output  1  frame in progress or result pending.

Behaviour:
- Reset (async assert, takes effect immediately):
  - state=IDLE; acc=0, cnt=0, mode_q=0, ovf=0.
  - out_valid=0, out_data=0, out_ovf=0, busy=0, in_ready=1 (once out of reset).
- Beat accepted when in_valid && in_ready.
- Output transferred when out_valid && out_ready.
- cnt width is clog2(N)+1.
- IDLE:
  - in_ready=1, busy=0.
  - On accept: acc=in_data, mode_q=mode, ovf=0, cnt=1.
  - Next state is HOLD if N==1, else ACCUM.
- ACCUM:
  - in_ready=1, busy=1.
  - On accept: acc=f(acc,in_data,mode_q), cnt=cnt+1.
  - If the accepted beat is element N (cnt was N-1), next state is HOLD.
  - No accept: all state holds (bubbles allowed anywhere).
- HOLD:
  - out_valid=1, in_ready=0, busy=1.
  - out_data=acc, out_ovf=ovf, both stable while out_ready=0.
  - On transfer: next state IDLE, out_valid=0 the following cycle.
- Latency: out_valid rises the cycle after element N is accepted.
- Throughput: at most one frame per N+1 cycles; no overlap of HOLD with the next frame's input.
- Reduction functions:
  - sum, SIGNED=0: compute W+1-bit sum; if bit W is set, clamp to 2^W-1 and set ovf (sticky for the frame).
  - sum, SIGNED=1: clamp to 2^(W-1)-1 or -2^(W-1) on positive/negative overflow and set ovf.
  - max/min: compare per SIGNED; ties keep acc.
  - xor: bitwise.
- mode changes mid-frame are ignored; mode_q governs the whole frame.
- in_data when in_valid=0 is don't-care and must not affect state.
- Reset asserted mid-frame or during HOLD: partial frame and pending result are discarded; the next accepted word starts a fresh frame.

Test Plan:
- SIGNED=0, N=8, mode=0, inputs 1..8 back-to-back, out_ready=1 -> out_data=36, out_ovf=0, out_valid high exactly 1 cycle after 8th accept.
- Same inputs, modes 1/2/3 in three consecutive frames -> out_data 8, 1, 8 respectively; out_ovf=0.
- mode=0, eight words of 0xFF -> out_data=0xFF, out_ovf=1.
  - Next frame, mode=0, inputs 1..8 -> out_data=36, out_ovf=0 (sticky clears per frame).
- SIGNED=1, mode=1, inputs {0x80,0xFF,0x05,0x7F,0x00,0x90,0x01,0xC0} -> out_data=0x7F.
  - Same inputs with mode=2 -> out_data=0x80.
- Backpressure and bubbles:
  - Inputs 1..8 with in_valid low every other cycle -> result 36.
  - Hold out_ready=0 for 5 cycles -> out_data stable at 36, in_ready=0, busy=1 throughout.
  - Raise out_ready -> IDLE next cycle.
- Mid-frame reset and mode change:
  - Accept 3 words, pulse rst, then send inputs 1..8 with mode=1 -> out_data=8, no spurious out_valid before the 8th accept.
  - Toggle mode to 3 on beat 4 -> result still 8.
